// File: rtl/alu_pkg.sv
// alu_pkg: shared multiply-unit types and constants used by decode and the sequencer
package alu_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;
  localparam int MUL_WIDTH = 16;
  localparam logic [3:0] OP_MUL = 4'd10;
endpackage

// File: rtl/mul_step.sv
// mul_step: one add-and-shift iteration of the unsigned multiplier datapath
module mul_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH:0]   p,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH:0]   p_next
);
  logic [WIDTH:0] upper;
  // add the multiplicand into {carry, upper} when the current multiplier bit is set, then shift right
  always_comb begin
    upper  = p[0] ? p[2*WIDTH:WIDTH] + {1'b0, m} : p[2*WIDTH:WIDTH];
    p_next = {1'b0, upper, p[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle 16x16 unsigned multiply controller producing HI/LO words
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  mul_state_t       state_q, state_d;
  logic [2*WIDTH:0] p_q, p_d, p_step;
  logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mul_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .m      (m_q),
    .p_next (p_step)
  );
  // next-state: accept in IDLE, iterate in RUN (cancel wins), single DONE cycle
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        m_d     = op_a;
        p_d     = {{(WIDTH+1){1'b0}}, op_b};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (cancel) begin
        state_d = IDLE;
      end else begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = p_step[2*WIDTH-1:WIDTH];
          lo_d    = p_step[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer
module tb_mul_sequencer;
  logic        clk = 0;
  logic        rst = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [15:0] op_a = 0;
  logic [15:0] op_b = 0;
  logic        cancel = 0;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  int tests = 0;
  int fails = 0;

  mul_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eh, input logic [15:0] el);
    int n;
    @(negedge clk);
    chk("ready_before", {31'b0, req_ready}, 1);
    req_valid = 1; op_a = a; op_b = b;
    @(negedge clk);
    req_valid = 0; op_a = ~a; op_b = ~b;
    chk("busy_run", {31'b0, busy}, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 16);
    chk("hi", {16'b0, hi}, {16'b0, eh});
    chk("lo", {16'b0, lo}, {16'b0, el});
    @(negedge clk);
    chk("ready_after", {31'b0, req_ready}, 1);
    chk("done_single", {31'b0, done}, 0);
  endtask

  initial begin
    int seen;
    int last_acc;
    int n_done;
    logic [15:0] acc_a, acc_b;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_hilo", {hi, lo}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    run_mul(16'd3, 16'd5, 16'h0000, 16'h000F);
    run_mul(16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    run_mul(16'h1234, 16'h0010, 16'h0001, 16'h2340);
    run_mul(16'h0000, 16'hABCD, 16'h0000, 16'h0000);
    run_mul(16'd7, 16'd9, 16'h0000, 16'h003F);

    @(negedge clk);
    req_valid = 1; op_a = 16'h0100; op_b = 16'h0100;
    @(negedge clk);
    req_valid = 0;
    repeat (4) @(negedge clk);
    chk("cancel_busy", {31'b0, busy}, 1);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    chk("cancel_ready", {31'b0, req_ready}, 1);
    chk("cancel_nodone", {31'b0, done}, 0);
    chk("cancel_hilo", {hi, lo}, 32'h0000_003F);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("cancel_quiet", seen, 0);
    run_mul(16'd2, 16'd2, 16'h0000, 16'h0004);

    @(negedge clk);
    req_valid = 1;
    last_acc = -1;
    n_done = 0;
    acc_a = 0;
    acc_b = 0;
    for (int i = 0; i < 58; i++) begin
      op_a = 16'(100 + i * 7);
      op_b = 16'(3 + i * 13);
      if (done) begin
        n_done++;
        chk("hold_prod", {hi, lo}, 32'(acc_a) * 32'(acc_b));
      end
      if (req_ready) begin
        if (last_acc >= 0) chk("hold_spacing", i - last_acc, 18);
        last_acc = i;
        acc_a = op_a;
        acc_b = op_b;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("hold_dones", n_done, 3);
    while (!req_ready) @(negedge clk);

    @(negedge clk);
    req_valid = 1; op_a = 16'h00FF; op_b = 16'h00FF;
    @(negedge clk);
    req_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_ready", {31'b0, req_ready}, 1);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_hilo", {hi, lo}, 32'h0);
    @(negedge clk);
    rst = 1;
    run_mul(16'd6, 16'd7, 16'h0000, 16'h002A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller that takes over the 16×16 multiply from the single-cycle ALU path and produces the 32-bit product as HI/LO words. Sequences an add-and-shift datapath over WIDTH cycles with a valid/ready request handshake, a one-cycle done pulse and a cancel input. Sits beside the ALU; decode steers multiply opcodes here and stalls issue while `busy` is high.

## Interface
- `WIDTH`, 16, operand width; product is 2·WIDTH bits; `WIDTH` ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  multiply request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `op_a`  in  WIDTH  multiplicand; sampled only on accept.
- `op_b`  in  WIDTH  multiplier; sampled only on accept.
- `cancel`  in  1  abort the in-flight multiply.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are new and valid.
- `hi`  out  WIDTH  upper product word; holds until the next completed multiply.
- `lo`  out  WIDTH  lower product word; holds until the next completed multiply.

## Operation
- Arithmetic is unsigned. Product = `op_a`·`op_b`, exact, 2·WIDTH bits, no truncation.
- Working register P is 2·WIDTH+1 bits: {carry, upper, lower}. Multiplicand register M is WIDTH bits. Iteration counter `cnt` is clog2(WIDTH) bits.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - Accept when `req_valid`=1 at a rising edge: M←`op_a`, P←{0, 0…0, `op_b`}, `cnt`←0, go to RUN.
- RUN, on each edge:
  - If P[0]=1, upper+carry ← P[2W:W] + M. Then shift P right by 1.
  - `cnt`++.
  - On the edge where `cnt`=WIDTH−1: `hi`←final P[2W−1:W], `lo`←final P[W−1:0], go to DONE.
- DONE: `done`=1 for exactly this cycle. Next edge goes to IDLE.
- `cancel`:
  - Honoured only in RUN. Next state is IDLE.
  - `hi`/`lo` keep their previous values and `done` does not pulse.
  - Ignored in IDLE and DONE. A request and `cancel` together in IDLE: the request is accepted.
- `op_a`/`op_b` changes after the accept edge have no effect.
- `req_valid` outside IDLE is not consumed. The requester holds it until `req_ready`.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `busy`=0, `done`=0, `hi`=0, `lo`=0. P, M and `cnt` reset to 0.
- Reset asserted mid-RUN aborts immediately (asynchronous). No `done`; `hi`/`lo` read 0.
- Latency, with accept at edge E0:
  - Iterations run at edges E1…E_W.
  - `hi`/`lo` update and `done` rises at E_W.
  - IDLE is re-entered at E_W+1.
- Earliest next accept is edge E_W+2. Throughput is one multiply per WIDTH+2 cycles; 18 cycles at WIDTH=16.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.

## Structure
- Shared package `alu_pkg`:
  - State enum `mul_state_t` {IDLE, RUN, DONE}.
  - Default `MUL_WIDTH`=16.
  - Multiply opcode constant (10), used by decode to steer here.
- One combinational sub-module `mul_step`: P,M in → next P out, doing conditional add then shift right by 1. Keeps the datapath separate from the FSM and lets it be unit-tested.
- Control FSM, counter and HI/LO output registers live in `mul_sequencer`.

## Test plan
- Reset, then `op_a`=3, `op_b`=5 → `done` pulses exactly 16 cycles after the accept edge; `hi`=0x0000, `lo`=0x000F; `req_ready` returns 1 one cycle later.
- `op_a`=0xFFFF, `op_b`=0xFFFF → `hi`=0xFFFE, `lo`=0x0001. This exercises the carry bit.
- `op_a`=0x1234, `op_b`=0x0010 → `hi`=0x0001, `lo`=0x2340. Then `op_a`=0, `op_b`=0xABCD → `hi`=`lo`=0.
- Complete 7×9 (`lo`=0x003F). Start 0x0100×0x0100, assert `cancel` on the 5th RUN cycle → no `done`, `hi`/`lo` stay 0x0000/0x003F, `req_ready`=1 next cycle. Then 2×2 completes with `lo`=4.
- Hold `req_valid` high continuously with changing operands → accepts only when `req_ready`=1, spaced 18 cycles apart. Each result matches the operands sampled at its own accept edge.
- Deassert `rst` mid-RUN, asynchronously between edges → outputs go to reset values immediately. After release, 6×7 gives `lo`=0x002A.
